comp_seq_tx: RTL and testbench

Parallel-to-serial transmitter that drives the MSB-first bit-serial comparator.
- Captures two WIDTH-bit operands on a start pulse.
- Issues a one-cycle clear pulse to the downstream comparator.
- Shifts both operands out MSB first, one bit pair per clock.
- Signals completion, so the comparator's less-than and equal outputs are valid in the done cycle.

---
 rtl/comp_seq_tx.sv | 117 +++++++++++
 tb/tb_comp_seq_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_seq_tx.sv
// MSB-first parallel-to-serial transmitter feeding a bit-serial comparator.
// Optional reference outputs exp_lt/exp_eq are built when COMP_SEQ_TX_REF_EN is defined.
module comp_seq_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_out,
    output logic             b_out,
    output logic             frame_rst,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
`ifdef COMP_SEQ_TX_REF_EN
    ,
    output logic             exp_lt,
    output logic             exp_eq
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == CW'(1));

    // Outputs are registered: each is set on the edge that enters the cycle it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cnt     <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            frame_rst <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            frame_rst <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_sh_a    <= a_in;
                        r_sh_b    <= b_in;
                        frame_rst <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_cnt     <= CW'(WIDTH);
                    a_out     <= r_sh_a[WIDTH-1];
                    b_out     <= r_sh_b[WIDTH-1];
                    bit_valid <= 1'b1;
                    busy      <= 1'b1;
                    r_sh_a    <= r_sh_a << 1;
                    r_sh_b    <= r_sh_b << 1;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - CW'(1);
                    // r_cnt counts bits still on the wire, including the current one.
                    if (w_last) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        a_out     <= r_sh_a[WIDTH-1];
                        b_out     <= r_sh_b[WIDTH-1];
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        r_sh_a    <= r_sh_a << 1;
                        r_sh_b    <= r_sh_b << 1;
                    end
                end
            endcase
        end
    end

`ifdef COMP_SEQ_TX_REF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_lt <= 1'b0;
            exp_eq <= 1'b0;
        end else if (w_accept) begin
            exp_lt <= (a_in < b_in);
            exp_eq <= (a_in == b_in);
        end
    end
`endif

endmodule

// File: tb/tb_comp_seq_tx.sv
// Directed self-checking bench for comp_seq_tx (WIDTH=8 and WIDTH=1 instances)
// with a small behavioural MSB-first comparator model on the serial outputs.
module tb_comp_seq_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       a_out, b_out, frame_rst, bit_valid, busy, done;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       a_out1, b_out1, frame_rst1, bit_valid1, busy1, done1;

`ifdef COMP_SEQ_TX_REF_EN
    logic exp_lt, exp_eq, exp_lt1, exp_eq1;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    comp_seq_tx #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_in(a_in), .b_in(b_in),
        .a_out(a_out), .b_out(b_out), .frame_rst(frame_rst),
        .bit_valid(bit_valid), .busy(busy), .done(done)
`ifdef COMP_SEQ_TX_REF_EN
        , .exp_lt(exp_lt), .exp_eq(exp_eq)
`endif
    );

    comp_seq_tx #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a_in(a1), .b_in(b1),
        .a_out(a_out1), .b_out(b_out1), .frame_rst(frame_rst1),
        .bit_valid(bit_valid1), .busy(busy1), .done(done1)
`ifdef COMP_SEQ_TX_REF_EN
        , .exp_lt(exp_lt1), .exp_eq(exp_eq1)
`endif
    );

    // {frame_rst, busy, bit_valid, done, a_out, b_out}
    wire [5:0] o  = {frame_rst, busy, bit_valid, done, a_out, b_out};
    wire [5:0] o1 = {frame_rst1, busy1, bit_valid1, done1, a_out1, b_out1};

    // Downstream MSB-first comparator model
    logic cmp_lt, cmp_eq;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_lt <= 1'b0;
            cmp_eq <= 1'b0;
        end else if (frame_rst) begin
            cmp_lt <= 1'b0;
            cmp_eq <= 1'b1;
        end else if (bit_valid && cmp_eq && (a_out != b_out)) begin
            cmp_lt <= b_out;
            cmp_eq <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (o !== 6'b0 || o1 !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_held got %b/%b want 000000", o, o1);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (o !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle got %b want 000000", o);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt, exp_eq} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_exp got %b want 00", {exp_lt, exp_eq});
        end
`endif
    endtask

    task automatic test_equal();
        logic [7:0] ea = 8'hA5;
        a_in = 8'hA5; b_in = 8'hA5; start = 1'b1;
        tick();
        start = 1'b0; a_in = 8'h00; b_in = 8'hFF;
        n_checks++;
        if (o !== 6'b110000) begin
            n_fail++;
            $display("FAIL eq_clear got %b want 110000", o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (o !== {4'b0110, ea[7-i], ea[7-i]}) begin
                n_fail++;
                $display("FAIL eq_bit%0d got %b want 0110%b%b", i, o, ea[7-i], ea[7-i]);
            end
        end
        tick();
        n_checks++;
        if (o !== 6'b000100 || {cmp_lt, cmp_eq} !== 2'b01) begin
            n_fail++;
            $display("FAIL eq_done got %b cmp %b%b want 000100 cmp 01", o, cmp_lt, cmp_eq);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt, exp_eq} !== 2'b01) begin
            n_fail++;
            $display("FAIL eq_exp got %b want 01", {exp_lt, exp_eq});
        end
`endif
        tick();
        n_checks++;
        if (o !== 6'b0) begin
            n_fail++;
            $display("FAIL eq_idle got %b want 000000", o);
        end
    endtask

    task automatic test_less();
        logic [7:0] ea = 8'h3C;
        logic [7:0] eb = 8'h3D;
        a_in = ea; b_in = eb; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (o !== 6'b110000) begin
            n_fail++;
            $display("FAIL lt_clear got %b want 110000", o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (o !== {4'b0110, ea[7-i], eb[7-i]}) begin
                n_fail++;
                $display("FAIL lt_bit%0d got %b want 0110%b%b", i, o, ea[7-i], eb[7-i]);
            end
        end
        tick();
        n_checks++;
        if (o !== 6'b000100 || {cmp_lt, cmp_eq} !== 2'b10) begin
            n_fail++;
            $display("FAIL lt_done got %b cmp %b%b want 000100 cmp 10", o, cmp_lt, cmp_eq);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt, exp_eq} !== 2'b10) begin
            n_fail++;
            $display("FAIL lt_exp got %b want 10", {exp_lt, exp_eq});
        end
`endif
        tick();
    endtask

    task automatic test_ignore_start();
        logic [7:0] ea = 8'h3C;
        logic [7:0] eb = 8'h3D;
        int ndone = 0;
        a_in = ea; b_in = eb; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = (i == 1 || i == 4);
            a_in = 8'hFF; b_in = 8'h00;
            n_checks++;
            if (o !== {4'b0110, ea[7-i], eb[7-i]}) begin
                n_fail++;
                $display("FAIL ign_bit%0d got %b want 0110%b%b", i, o, ea[7-i], eb[7-i]);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) ndone++;
            n_checks++;
            if (frame_rst !== 1'b0 || bit_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ign_tail%0d got %b want no frame", i, o);
            end
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL ign_done_count got %0d want 1", ndone);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt, exp_eq} !== 2'b10) begin
            n_fail++;
            $display("FAIL ign_exp got %b want 10", {exp_lt, exp_eq});
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea = 8'h12;
        logic [7:0] eb = 8'h34;
        a_in = ea; b_in = eb; start = 1'b1;
        tick();
        a_in = 8'hFF; b_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (o !== {4'b0110, ea[7-i], eb[7-i]}) begin
                n_fail++;
                $display("FAIL b2b1_bit%0d got %b want 0110%b%b", i, o, ea[7-i], eb[7-i]);
            end
        end
        tick();
        n_checks++;
        if (o !== 6'b000100 || {cmp_lt, cmp_eq} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b1_done got %b cmp %b%b want 000100 cmp 10", o, cmp_lt, cmp_eq);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (o !== 6'b110000) begin
            n_fail++;
            $display("FAIL b2b2_clear got %b want 110000", o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (o !== 6'b011010) begin
                n_fail++;
                $display("FAIL b2b2_bit%0d got %b want 011010", i, o);
            end
        end
        tick();
        n_checks++;
        if (o !== 6'b000100 || {cmp_lt, cmp_eq} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b2_done got %b cmp %b%b want 000100 cmp 00", o, cmp_lt, cmp_eq);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt, exp_eq} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b2_exp got %b want 00", {exp_lt, exp_eq});
        end
`endif
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] ea = 8'hC3;
        logic [7:0] eb = 8'h81;
        int ndone = 0;
        a_in = 8'h5A; b_in = 8'h5A; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (o !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_immediate got %b want 000000", o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || frame_rst) ndone++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || frame_rst) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL abort_no_pulse got %0d pulses want 0", ndone);
        end
        a_in = ea; b_in = eb; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (o !== 6'b110000) begin
            n_fail++;
            $display("FAIL abort_clear got %b want 110000", o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (o !== {4'b0110, ea[7-i], eb[7-i]}) begin
                n_fail++;
                $display("FAIL abort_bit%0d got %b want 0110%b%b", i, o, ea[7-i], eb[7-i]);
            end
        end
        tick();
        n_checks++;
        if (o !== 6'b000100 || {cmp_lt, cmp_eq} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_done got %b cmp %b%b want 000100 cmp 00", o, cmp_lt, cmp_eq);
        end
        tick();
    endtask

    task automatic test_width1();
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
        n_checks++;
        if (o1 !== 6'b110000) begin
            n_fail++;
            $display("FAIL w1_clear got %b want 110000", o1);
        end
        tick();
        n_checks++;
        if (o1 !== 6'b011001) begin
            n_fail++;
            $display("FAIL w1_bit got %b want 011001", o1);
        end
        tick();
        n_checks++;
        if (o1 !== 6'b000100) begin
            n_fail++;
            $display("FAIL w1_done got %b want 000100", o1);
        end
`ifdef COMP_SEQ_TX_REF_EN
        n_checks++;
        if ({exp_lt1, exp_eq1} !== 2'b10) begin
            n_fail++;
            $display("FAIL w1_exp got %b want 10", {exp_lt1, exp_eq1});
        end
`endif
        tick();
        n_checks++;
        if (o1 !== 6'b0) begin
            n_fail++;
            $display("FAIL w1_idle got %b want 000000", o1);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_equal();
        test_less();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
